// File: rtl/tdm_demux16.sv
// Receive end of a 16-slot TDM link: steers accepted beats into slot registers,
// publishes each complete frame in parallel, and re-locks on framing errors.
module tdm_demux16 #(
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    input  logic                  sync,
    output logic [16*WIDTH-1:0]   dout,
    output logic                  frame_valid,
    output logic [3:0]            slot,
    output logic                  locked,
    output logic                  sync_err
);

    typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

    state_t                state_q;
    logic [3:0]            slot_q;
    logic [16*WIDTH-1:0]   shadow_q;
    logic [16*WIDTH-1:0]   dout_q;
    logic                  frame_valid_q;
    logic                  sync_err_q;
    logic                  locked_q;
    logic [3:0]            slot_d;

    assign slot_d = slot_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 4'd0;
            shadow_q      <= '0;
            dout_q        <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            locked_q      <= 1'b0;
        end else begin
            // Strobes last exactly one cycle; idle beats leave all other state alone.
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (din_valid) begin
                case (state_q)
                    HUNT: begin
                        if (sync) begin
                            shadow_q[WIDTH-1:0] <= din;
                            slot_q              <= 4'd1;
                            state_q             <= RUN;
                            locked_q            <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (sync) begin
                            if (slot_q != 4'd0) begin
                                // Early sync: drop the partial frame, this beat starts a new one.
                                sync_err_q <= 1'b1;
                                shadow_q   <= {{(15*WIDTH){1'b0}}, din};
                            end else begin
                                shadow_q[WIDTH-1:0] <= din;
                            end
                            slot_q <= 4'd1;
                        end else if (slot_q == 4'd0) begin
                            sync_err_q <= 1'b1;
                            state_q    <= HUNT;
                            locked_q   <= 1'b0;
                        end else if (slot_q == 4'd15) begin
                            dout_q        <= {din, shadow_q[15*WIDTH-1:0]};
                            frame_valid_q <= 1'b1;
                            slot_q        <= 4'd0;
                        end else begin
                            shadow_q[int'(slot_q)*WIDTH +: WIDTH] <= din;
                            slot_q                                <= slot_d;
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        slot_q   <= 4'd0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign dout        = dout_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = locked_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux16.sv
// Directed bench for tdm_demux16 (WIDTH=1): expected frames are queued as the
// final beat is driven and checked whenever frame_valid appears.
module tb_tdm_demux16;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  din;
    logic        din_valid;
    logic        sync;
    logic [15:0] dout;
    logic        frame_valid;
    logic [3:0]  slot;
    logic        locked;
    logic        sync_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done = 0;
    int gap      = 0;
    logic [15:0] exp_q[$];

    tdm_demux16 #(.WIDTH(1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
        .dout(dout), .frame_valid(frame_valid), .slot(slot), .locked(locked),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every frame_valid must match the oldest queued frame.
    always @(negedge clk) begin
        if (frame_valid) begin
            if (exp_q.size() == 0) chk("unexpected_frame", {16'h0, dout}, 32'hFFFF_FFFF);
            else chk("sb_dout", {16'h0, dout}, {16'h0, exp_q.pop_front()});
        end
        if (frame_valid && sync_err) chk("fv_and_err", 1, 0);
    end

    task automatic drive(input logic v, input logic s, input logic d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    // Drives slots lo..hi of pattern pat; sync on the first beat when sf=1.
    task automatic beats(input logic [15:0] pat, input int lo, input int hi, input logic sf);
        for (int k = lo; k <= hi; k++) begin
            if (k == 15) exp_q.push_back(pat);
            drive(1'b1, sf && (k == lo), pat[k]);
            if (k == 15) begin
                chk("fv_at_15", frame_valid, 1);
                chk("dout_at_15", dout, pat);
                chk("slot_wrap", slot, 0);
                gap = cyc - last_done;
                last_done = cyc;
            end
        end
    endtask

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0; sync = 1'b0;
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        chk("rst_dout", dout, 0);
        chk("rst_slot", slot, 0);
        chk("rst_locked", locked, 0);
        chk("rst_fv", frame_valid, 0);
        chk("rst_err", sync_err, 0);
        rst = 1'b0;

        // HUNT discards unsynced beats silently
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        chk("hunt_locked", locked, 0);
        chk("hunt_slot", slot, 0);
        chk("hunt_err", sync_err, 0);

        // First frame: slot 0 only
        drive(1'b1, 1'b1, 1'b1);
        chk("lock_beat0", locked, 1);
        chk("slot_beat0", slot, 1);
        beats(16'h0001, 1, 15, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("fv_drop", frame_valid, 0);
        chk("dout_hold", dout, 16'h0001);

        // Back-to-back frames at full rate
        beats(16'h0020, 0, 15, 1'b1);
        beats(16'h0400, 0, 15, 1'b1);
        chk("gap_0400", gap, 16);
        beats(16'h8000, 0, 15, 1'b1);
        chk("gap_8000", gap, 16);

        // Stall for 3 cycles after slot 7
        beats(16'h0200, 0, 7, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            chk("stall_slot", slot, 8);
            chk("stall_fv", frame_valid, 0);
        end
        beats(16'h0200, 8, 15, 1'b0);
        chk("gap_stall", gap, 19);

        // Early sync on beat 6
        beats(16'hFFFF, 0, 5, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        chk("early_err", sync_err, 1);
        chk("early_slot", slot, 1);
        chk("early_locked", locked, 1);
        chk("early_dout", dout, 16'h0200);
        beats(16'h0008, 1, 1, 1'b0);
        chk("early_err_drop", sync_err, 0);
        beats(16'h0008, 2, 15, 1'b0);

        // Missing sync after a good frame
        drive(1'b1, 1'b0, 1'b1);
        chk("miss_err", sync_err, 1);
        chk("miss_locked", locked, 0);
        chk("miss_slot", slot, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1);
        chk("miss_err_drop", sync_err, 0);
        chk("miss_still_unlocked", locked, 0);
        chk("miss_slot_hold", slot, 0);
        chk("miss_dout_hold", dout, 16'h0008);

        // Reset at slot 11
        beats(16'hFFFF, 0, 10, 1'b1);
        chk("pre_rst_slot", slot, 11);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b1);
        chk("mid_rst_dout", dout, 0);
        chk("mid_rst_slot", slot, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_fv", frame_valid, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1);
        chk("post_rst_locked", locked, 0);
        chk("post_rst_dout", dout, 0);

        // Recovery with a mixed pattern
        beats(16'hA5C3, 0, 15, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        chk("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
